// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester IDs and the default memory depth.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  typedef enum logic {
    ReqCpu = 1'b0,
    ReqDma = 1'b1
  } req_id_e;

  localparam int unsigned DefaultMemWords = 64;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU and DMA request ports plus the
// memory port. The slave modport is the arbiter's view; master is the view of
// the requesters and the memory.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic              dma_err;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_err, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_err, dma_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_err, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_err, dma_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter_arb_pick2.sv
// Two-way combinational arbiter. A lone requester always wins; on a tie the
// requester that was not served last wins. Tying last to DMA yields a fixed
// CPU-first priority.
module arb_pick2
  import data_mem_arbiter_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_dma,
  input  req_id_e    last,
  output logic [1:0] grant   // bit 0 = CPU, bit 1 = DMA
);

  // One-hot grant decision
  always_comb begin
    grant = 2'b00;
    if (req_cpu && req_dma) begin
      grant = (last == ReqCpu) ? 2'b10 : 2'b01;
    end else if (req_cpu) begin
      grant = 2'b01;
    end else if (req_dma) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a CPU and a DMA requester onto one single-port data memory with a
// three-state IDLE/ACCESS/DONE sequence. Out-of-range word addresses complete
// with err set and never write.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on simultaneous
// requests; otherwise the CPU always wins a tie.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = DefaultMemWords
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);

  state_e            state_q;
  req_id_e           grant_q;
  logic              in_range_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_ack_q, dma_ack_q;
  logic              cpu_err_q, dma_err_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  req_id_e           last_served;
  logic [1:0]        pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_q;
  assign last_served = last_q;
`else
  assign last_served = ReqDma;
`endif

  arb_pick2 u_arb (
    .req_cpu (bus.cpu_req),
    .req_dma (bus.dma_req),
    .last    (last_served),
    .grant   (pick)
  );

  // Select the candidate winner's request fields and range-check its word index
  always_comb begin
    if (pick[1]) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end else begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end
    sel_in_range = {2'b00, sel_addr[ADDR_W-1:2]} < ADDR_W'(MEM_WORDS);
  end

  // FSM with registered memory-port and requester outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= ReqCpu;
      in_range_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dma_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= ReqDma;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick != 2'b00) begin
            state_q     <= StAccess;
            grant_q     <= pick[1] ? ReqDma : ReqCpu;
            in_range_q  <= sel_in_range;
            mem_we_q    <= sel_we & sel_in_range;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= pick[1] ? ReqDma : ReqCpu;
`endif
          end
        end
        StAccess: begin
          state_q     <= StDone;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          // Read data is captured here even for writes (pre-write contents)
          if (grant_q == ReqDma) begin
            dma_ack_q   <= 1'b1;
            dma_err_q   <= ~in_range_q;
            dma_rdata_q <= in_range_q ? bus.mem_rdata : '0;
          end else begin
            cpu_ack_q   <= 1'b1;
            cpu_err_q   <= ~in_range_q;
            cpu_rdata_q <= in_range_q ? bus.mem_rdata : '0;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          cpu_err_q <= 1'b0;
          dma_err_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.dma_err   = dma_err_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: reset values, back-to-back
// arbitration from reset, a vector table of single transactions, dropped
// request, reset during a write, then randomized traffic against a
// transaction-level memory model.
module tb_data_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 64;
  localparam time         TCLK  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_ram = 1'b0;
  always #(TCLK / 2) clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_WORDS (WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Attached memory
  logic [DW-1:0] ram [WORDS];
  int unsigned   we_pulses = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic bit in_range(input logic [31:0] addr);
    return (addr >> 2) < WORDS;
  endfunction

  assign bus.mem_rdata = in_range(bus.mem_addr) ? ram[bus.mem_addr[7:2]] : '0;

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < int'(WORDS); i++) ram[i] <= init_word(i);
    end else if (bus.mem_we) begin
      we_pulses <= we_pulses + 1;
      if (in_range(bus.mem_addr)) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int r);
    return (r != 0) ? bus.dma_ack : bus.cpu_ack;
  endfunction

  function automatic logic err_of(input int r);
    return (r != 0) ? bus.dma_err : bus.cpu_err;
  endfunction

  function automatic logic [31:0] rdata_of(input int r);
    return (r != 0) ? bus.dma_rdata : bus.cpu_rdata;
  endfunction

  task automatic drive(input int r, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (r != 0) begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  task automatic clear_inputs();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    init_ram = 1'b1;
    tick();
    init_ram = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One transaction from IDLE with the fixed two-edge latency checked
  task automatic run_txn(input string tag, input int r, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input bit exp_err);
    int unsigned p0;
    bit exp_we;
    p0 = we_pulses;
    exp_we = we && in_range(addr);
    drive(r, 1'b1, we, addr, wdata);
    tick();
    check({tag, " access.mem_addr"}, bus.mem_addr, addr);
    check({tag, " access.mem_wdata"}, bus.mem_wdata, wdata);
    check({tag, " access.mem_we"}, bus.mem_we, exp_we);
    check({tag, " access.ack"}, ack_of(r), 1'b0);
    tick();
    check({tag, " done.ack"}, ack_of(r), 1'b1);
    check({tag, " done.other_ack"}, ack_of(1 - r), 1'b0);
    check({tag, " done.err"}, err_of(r), exp_err);
    check({tag, " done.rdata"}, rdata_of(r), exp_rdata);
    check({tag, " done.other_rdata"}, rdata_of(1 - r), exp_rd[1 - r]);
    check({tag, " done.mem_we"}, bus.mem_we, 1'b0);
    check({tag, " done.mem_addr"}, bus.mem_addr, 32'h0);
    exp_rd[r] = exp_rdata;
    drive(r, 1'b0, 1'b0, '0, '0);
    tick();
    check({tag, " idle.ack"}, ack_of(r), 1'b0);
    check({tag, " we_pulses"}, we_pulses - p0, 32'(exp_we));
  endtask

  typedef struct {
    int          r;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t vecs [8];

  // Random-section state
  logic [31:0] model_mem [WORDS];
  bit          pend [2];
  bit          op_we [2];
  logic [31:0] op_addr [2];
  logic [31:0] op_wdata [2];
  int          op_start [2];

  initial begin
    int last;
    int model_writes;
    int unsigned p0;
    bit abort;

    // Reset values
    clear_inputs();
    init_ram = 1'b1;
    tick();
    init_ram = 1'b0;
    check("rst.mem_we", bus.mem_we, 1'b0);
    check("rst.mem_addr", bus.mem_addr, 32'h0);
    check("rst.mem_wdata", bus.mem_wdata, 32'h0);
    check("rst.cpu_ack", bus.cpu_ack, 1'b0);
    check("rst.dma_ack", bus.dma_ack, 1'b0);
    check("rst.cpu_err", bus.cpu_err, 1'b0);
    check("rst.dma_err", bus.dma_err, 1'b0);
    check("rst.cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst.dma_rdata", bus.dma_rdata, 32'h0);

    // Both requesting continuously from reset release
    drive(0, 1'b1, 1'b0, 32'h0, '0);
    drive(1, 1'b1, 1'b0, 32'h4, '0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      bit ec, ed;
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      ec = (k == 2) || (k == 8);
      ed = (k == 5) || (k == 11);
`else
      ec = (k == 2) || (k == 5) || (k == 8) || (k == 11);
      ed = 1'b0;
`endif
      check($sformatf("cont.cpu_ack@%0d", k), bus.cpu_ack, ec);
      check($sformatf("cont.dma_ack@%0d", k), bus.dma_ack, ed);
      if (ec) check($sformatf("cont.cpu_rdata@%0d", k), bus.cpu_rdata, init_word(0));
      if (ed) check($sformatf("cont.dma_rdata@%0d", k), bus.dma_rdata, init_word(1));
    end
    clear_inputs();
    repeat (3) tick();

    // Vector table of single transactions
    do_reset();
    vecs[0] = '{0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h1000_0002, 1'b0};
    vecs[1] = '{1, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0,         1'b1};
    vecs[3] = '{0, 1'b0, 32'h0000_0006, 32'h0,         32'h1000_0001, 1'b0};
    vecs[4] = '{1, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h1000_003F, 1'b0};
    vecs[5] = '{1, 1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[6] = '{1, 1'b0, 32'h0000_0104, 32'h0,         32'h0,         1'b1};
    vecs[7] = '{0, 1'b0, 32'h0000_0003, 32'h0,         32'h1000_0000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].err);
    end
    check("vec.ram2", ram[2], 32'hDEAD_BEEF);
    check("vec.ram63", ram[63], 32'hCAFE_F00D);

    // Request dropped right after being sampled still completes
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h10, '0);
    tick();
    check("drop.cpu_ack", bus.cpu_ack, 1'b1);
    check("drop.cpu_rdata", bus.cpu_rdata, init_word(4));
    exp_rd[0] = init_word(4);
    tick();

    // Reset asserted during the ACCESS cycle of a write
    drive(0, 1'b1, 1'b1, 32'h4, 32'h55);
    tick();
    check("rstacc.mem_we_before", bus.mem_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rstacc.mem_we", bus.mem_we, 1'b0);
    check("rstacc.mem_addr", bus.mem_addr, 32'h0);
    check("rstacc.mem_wdata", bus.mem_wdata, 32'h0);
    clear_inputs();
    tick();
    check("rstacc.ram1", ram[1], init_word(1));
    check("rstacc.cpu_ack", bus.cpu_ack, 1'b0);
    check("rstacc.cpu_rdata", bus.cpu_rdata, 32'h0);
    rst_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    run_txn("rstacc.after", 1, 1'b0, 32'h4, 32'h0, init_word(1), 1'b0);

    // Randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < int'(WORDS); i++) model_mem[i] = init_word(i);
    for (int r = 0; r < 2; r++) pend[r] = 1'b0;
    last = 1;
    model_writes = 0;
    p0 = we_pulses;
    abort = 1'b0;
    for (int k = 0; k < 1500 && !abort; k++) begin
      if (bus.cpu_ack && bus.dma_ack) check("rnd.dual_ack", 32'h1, 32'h0);
      for (int r = 0; r < 2; r++) begin
        if (ack_of(r)) begin
          logic [31:0] er;
          bit ee;
          bit competing;
          check($sformatf("rnd.ack_pending r%0d", r), pend[r], 1'b1);
          if (in_range(op_addr[r])) begin
            er = model_mem[op_addr[r] >> 2];
            ee = 1'b0;
            if (op_we[r]) begin
              model_mem[op_addr[r] >> 2] = op_wdata[r];
              model_writes++;
            end
          end else begin
            er = '0;
            ee = 1'b1;
          end
          check($sformatf("rnd.rdata r%0d", r), rdata_of(r), er);
          check($sformatf("rnd.err r%0d", r), err_of(r), ee);
          check($sformatf("rnd.hold r%0d", 1 - r), rdata_of(1 - r), exp_rd[1 - r]);
          exp_rd[r] = er;
          // Grant was taken one edge before this ack became visible
          competing = pend[1 - r] && (op_start[1 - r] <= k - 2);
`ifdef ARB_ROUND_ROBIN_EN
          if (competing) check("rnd.rr_grant", r, 1 - last);
`else
          if (competing) check("rnd.fixed_grant", r, 0);
`endif
          last = r;
          pend[r] = 1'b0;
          drive(r, 1'b0, 1'b0, '0, '0);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(1, 0) != 0)) begin
          pend[r]     = 1'b1;
          op_we[r]    = ($urandom_range(1, 0) != 0);
          op_addr[r]  = 32'($urandom_range(0, 4 * WORDS + 15));
          op_wdata[r] = $urandom;
          op_start[r] = k;
          drive(r, 1'b1, op_we[r], op_addr[r], op_wdata[r]);
        end
        if (pend[r] && (k - op_start[r] > 100)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rnd.timeout r%0d: no ack after %0d cycles, want ack", r, k - op_start[r]);
          abort = 1'b1;
        end
      end
      tick();
    end
    clear_inputs();
    repeat (4) tick();
    check("rnd.we_pulses", we_pulses - p0, 32'(model_writes));
    for (int i = 0; i < int'(WORDS); i++) begin
      check($sformatf("rnd.ram[%0d]", i), ram[i], model_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
